// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/WB).
// Owns the architectural PC, the instruction register and the retire counter.
module core_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc,
  input  logic        dec_we,
  input  logic        dec_jmpe,
  input  logic        dec_be,
  input  logic [31:0] alu_result,
  input  logic        br_taken,
  output logic        rf_we,
  output logic [31:0] rf_wdata,
  output logic        retire,
  output logic [31:0] instret,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;
  localparam bit          TO_EN = (FETCH_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_FAULT
  } state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  ir_q, ir_d;
  logic [XLEN-1:0]  alu_q, alu_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  instret_q, instret_d;
  logic [1:0]       cause_q, cause_d;
  logic [XLEN-1:0]  pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      alu_q     <= '0;
      br_q      <= 1'b0;
      cnt_q     <= '0;
      instret_q <= '0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      alu_q     <= alu_d;
      br_q      <= br_d;
      cnt_q     <= cnt_d;
      instret_q <= instret_d;
      cause_q   <= cause_d;
    end
  end

  // Next-state and WB-cycle strobes
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    alu_d     = alu_q;
    br_d      = br_q;
    cnt_d     = cnt_q;
    instret_d = instret_q;
    cause_d   = cause_q;
    imem_req  = 1'b0;
    rf_we     = 1'b0;
    rf_wdata  = '0;
    retire    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        // A misaligned pc faults before any request leaves the core
        if (pc_q[1:0] != 2'b00) begin
          state_d = S_FAULT;
          cause_d = CAUSE_MISALIGN;
        end else begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_d    = imem_rdata;
            state_d = S_DECODE;
          end else if (TO_EN && (cnt_q == TO_LAST)) begin
            state_d = S_FAULT;
            cause_d = CAUSE_TIMEOUT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        alu_d   = alu_result;
        br_d    = br_taken;
        state_d = S_WB;
      end
      S_WB: begin
        rf_we     = dec_we;
        rf_wdata  = dec_jmpe ? pc_plus4 : alu_q;
        retire    = 1'b1;
        instret_d = instret_q + 32'd1;
        if (dec_jmpe)               pc_d = alu_q & ~32'h1;
        else if (dec_be && br_q)    pc_d = alu_q;
        else                        pc_d = pc_plus4;
        if (run) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign instret     = instret_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign fault       = (state_q == S_FAULT);
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: directed scenarios plus a randomized instruction
// stream, each instruction checked against a per-instruction behavioural model.
module tb_core_sequencer;
  localparam int unsigned TO     = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n, run, imem_ack, dec_we, dec_jmpe, dec_be, br_taken;
  logic [31:0] imem_rdata, alu_result;
  logic        imem_req, rf_we, retire, busy, fault;
  logic [31:0] imem_addr, ir, pc, rf_wdata, instret;
  logic [1:0]  fault_cause;

  always #5 clk = ~clk;

  core_sequencer #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .pc(pc), .dec_we(dec_we), .dec_jmpe(dec_jmpe), .dec_be(dec_be),
    .alu_result(alu_result), .br_taken(br_taken), .rf_we(rf_we), .rf_wdata(rf_wdata),
    .retire(retire), .instret(instret), .busy(busy), .fault(fault), .fault_cause(fault_cause)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] m_pc;
  logic [31:0] m_instret;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset mid-cycle, checks async clear, holds, then releases.
  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    dec_we = 1'b0; dec_jmpe = 1'b0; dec_be = 1'b0; alu_result = '0; br_taken = 1'b0;
    #1;
    total++;
    if ({imem_req, rf_we, retire, busy, fault, fault_cause} !== 7'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=%b", {imem_req, rf_we, retire, busy, fault, fault_cause}, 7'b0);
    end
    total++;
    if ({pc, imem_addr, ir, instret, rf_wdata} !== {RST_PC, RST_PC, 96'b0}) begin
      bad++; $display("FAIL reset_regs got=%h want=%h", {pc, imem_addr, ir, instret, rf_wdata}, {RST_PC, RST_PC, 96'b0});
    end
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      total++;
      if ({rf_we, retire, busy} !== 3'b0) begin
        bad++; $display("FAIL reset_hold got=%b want=000", {rf_we, retire, busy});
      end
    end
    step();
    rst_n = 1'b1;
    m_pc = RST_PC;
    m_instret = '0;
  endtask

  // n cycles in IDLE with run low, then raise run so FETCH follows.
  task automatic test_idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      run = 1'b0; imem_ack = 1'($urandom); imem_rdata = $urandom;
      @(negedge clk);
      total++;
      if ({busy, imem_req, retire, rf_we} !== 4'b0) begin
        bad++; $display("FAIL idle_flags got=%b want=0000", {busy, imem_req, retire, rf_we});
      end
      total++;
      if ({pc, instret} !== {m_pc, m_instret}) begin
        bad++; $display("FAIL idle_pc got=%h want=%h", {pc, instret}, {m_pc, m_instret});
      end
    end
    run = 1'b1;
  endtask

  // One instruction from its first FETCH cycle to its WB cycle. ended=1 when
  // the instruction faulted or was cut by reset (bench has already reset).
  task automatic run_instr(input logic [31:0] insn, input int ack_dly,
                           input logic we, input logic jmpe, input logic be, input logic br,
                           input logic [31:0] alu, input logic run_after,
                           input logic rst_exec, output logic ended);
    logic [31:0] npc, wdata;
    logic [1:0]  cause;
    bit          acked;
    acked = 0; ended = 1'b0; cause = 2'b00;
    for (int k = 0; k < 64 && !acked && cause == 2'b00; k++) begin
      step();
      imem_ack = (k == ack_dly); imem_rdata = (k == ack_dly) ? insn : $urandom;
      dec_we = 1'($urandom); dec_jmpe = 1'($urandom); dec_be = 1'($urandom);
      alu_result = $urandom; br_taken = 1'($urandom);
      @(negedge clk);
      if (k == 0) begin
        total++;
        if ({pc, instret} !== {m_pc, m_instret}) begin
          bad++; $display("FAIL fetch_pc got=%h want=%h", {pc, instret}, {m_pc, m_instret});
        end
      end
      if (m_pc[1:0] != 2'b00) begin
        total++;
        if (imem_req !== 1'b0) begin bad++; $display("FAIL misalign_req got=%b want=0", imem_req); end
        cause = 2'b01;
      end else begin
        total++;
        if ({imem_req, busy, rf_we, retire, imem_addr} !== {4'b1100, m_pc}) begin
          bad++; $display("FAIL fetch_req got=%h want=%h", {imem_req, busy, rf_we, retire, imem_addr}, {4'b1100, m_pc});
        end
        if (k == ack_dly) acked = 1;
        else if (k == int'(TO) - 1) cause = 2'b10;
      end
    end
    if (!acked && cause == 2'b00) begin
      bad++; total++; $display("FAIL fetch_bound got=noexit want=ack_or_fault");
      do_reset(); ended = 1'b1; return;
    end
    if (cause != 2'b00) begin
      for (int h = 0; h < 4; h++) begin
        step();
        imem_ack = 1'b1; imem_rdata = $urandom; run = 1'b1;
        @(negedge clk);
        total++;
        if ({fault, fault_cause, imem_req, busy, retire, pc} !== {1'b1, cause, 3'b000, m_pc}) begin
          bad++; $display("FAIL fault_state got=%h want=%h", {fault, fault_cause, imem_req, busy, retire, pc}, {1'b1, cause, 3'b000, m_pc});
        end
      end
      do_reset(); ended = 1'b1; return;
    end
    // DECODE
    step();
    imem_ack = 1'($urandom); imem_rdata = $urandom;
    dec_we = we; dec_jmpe = jmpe; dec_be = be; alu_result = $urandom; br_taken = 1'($urandom);
    @(negedge clk);
    total++;
    if ({ir, busy, imem_req, rf_we, retire} !== {insn, 4'b1000}) begin
      bad++; $display("FAIL decode got=%h want=%h", {ir, busy, imem_req, rf_we, retire}, {insn, 4'b1000});
    end
    // EXEC
    step();
    imem_ack = 1'($urandom); imem_rdata = $urandom; alu_result = alu; br_taken = br; run = run_after;
    @(negedge clk);
    total++;
    if ({busy, imem_req, rf_we, retire} !== 4'b1000) begin
      bad++; $display("FAIL exec got=%b want=1000", {busy, imem_req, rf_we, retire});
    end
    if (rst_exec) begin do_reset(); ended = 1'b1; return; end
    // WB
    step();
    imem_ack = 1'($urandom); imem_rdata = $urandom; alu_result = $urandom; br_taken = 1'($urandom);
    @(negedge clk);
    wdata = jmpe ? m_pc + 32'd4 : alu;
    if (jmpe)           npc = {alu[31:1], 1'b0};
    else if (be && br)  npc = alu;
    else                npc = m_pc + 32'd4;
    total++;
    if ({retire, rf_we, busy} !== {1'b1, we, 1'b1}) begin
      bad++; $display("FAIL wb_strobe got=%b want=%b", {retire, rf_we, busy}, {1'b1, we, 1'b1});
    end
    total++;
    if ({rf_wdata, ir, pc} !== {wdata, insn, m_pc}) begin
      bad++; $display("FAIL wb_data got=%h want=%h", {rf_wdata, ir, pc}, {wdata, insn, m_pc});
    end
    m_pc = npc;
    m_instret = m_instret + 32'd1;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_basic();
    logic e;
    test_idle(1);
    run_instr(32'h0050_0093, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 1'b1, 1'b0, e);
    for (int i = 0; i < 3; i++)
      run_instr($urandom, $urandom_range(0, 2), 1'b0, 1'b0, 1'b0, 1'b0, $urandom, 1'b1, 1'b0, e);
    run_instr(32'h0080_00ef, 1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h18, 1'b1, 1'b0, e);
    for (int i = 0; i < 2; i++)
      run_instr(32'h0000_0013, 0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, 1'b1, 1'b0, e);
    run_instr(32'h0200_0063, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 1'b0, e);
    run_instr(32'hfe1f_f06f, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 1'b0, e);
    run_instr(32'h0200_0063, 2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 1'b1, 1'b0, e);
  endtask

  task automatic test_misaligned();
    logic e;
    run_instr(32'h1030_00e7, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h103, 1'b1, 1'b0, e);
    run_instr($urandom, 0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, 1'b1, 1'b0, e);
    test_idle(1);
  endtask

  task automatic test_timeout();
    logic e;
    run_instr($urandom, 50, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, 1'b1, 1'b0, e);
    test_idle(1);
    run_instr(32'h0000_0013, int'(TO) - 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234, 1'b1, 1'b0, e);
    run_instr(32'h0000_0013, 0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, 1'b1, 1'b0, e);
  endtask

  task automatic test_run_drop();
    logic e;
    run_instr(32'h04d0_0093, 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd77, 1'b0, 1'b0, e);
    test_idle(3);
  endtask

  task automatic test_reset_in_exec();
    logic e;
    run_instr(32'h0010_0093, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1, 1'b1, 1'b1, e);
    test_idle(1);
  endtask

  task automatic test_wrap();
    logic e;
    run_instr(32'h0000_006f, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFD, 1'b1, 1'b0, e);
    run_instr(32'h0000_0013, 0, 1'b1, 1'b0, 1'b0, 1'b0, $urandom, 1'b1, 1'b0, e);
    run_instr(32'h0000_0013, 0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, 1'b1, 1'b0, e);
  endtask

  task automatic test_random();
    logic e, jmpe, be, ra;
    logic [31:0] tgt;
    int r, dly;
    for (int i = 0; i < 80; i++) begin
      r    = $urandom_range(0, 99);
      jmpe = (r < 15);
      be   = !jmpe && (r < 35);
      tgt  = 32'($urandom_range(0, 4095)) << 2;
      r    = $urandom_range(0, 99);
      if (r < 4) tgt = tgt | 32'h2;
      else if (r < 12) tgt = tgt | 32'h1;
      dly  = ($urandom_range(0, 9) == 0) ? int'(TO) + 2 : $urandom_range(0, int'(TO) - 1);
      ra   = ($urandom_range(0, 5) != 0);
      run_instr($urandom, dly, 1'($urandom), jmpe, be, 1'($urandom),
                (jmpe || be) ? tgt : $urandom, ra, 1'b0, e);
      if (e || !ra) test_idle($urandom_range(1, 3));
    end
    run_instr(32'h0000_0013, 0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, 1'b0, 1'b0, e);
    test_idle(2);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0;
    test_reset();
    test_basic();
    test_misaligned();
    test_timeout();
    test_run_drop();
    test_reset_in_exec();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the RV32I core. It fetches each instruction over a req/ack instruction-memory handshake and holds it in an instruction register that drives the instruction decoder. It then steps the decoded instruction through decode, execute and writeback, gating the register-file write and computing the next PC from the decoder's jump/branch flags. It sits between instruction memory, the decoder, the ALU/branch comparator and the register file, and owns the architectural PC.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FETCH_TIMEOUT, 255, max cycles in FETCH without ack before fault; 0 disables timeout; legal range 0..65535.
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- run  in  1  level; high = keep executing, low = stop at next instruction boundary.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (= pc).
- imem_ack  in  1  fetch complete; imem_rdata valid same cycle.
- imem_rdata  in  32  fetched instruction.
- ir  out  32  instruction register, drives decoder prog.
- pc  out  32  current PC, to ALU data1 mux.
- dec_we  in  1  decoder rd enable.
- dec_jmpe  in  1  decoder jump enable (JAL/JALR).
- dec_be  in  1  decoder branch enable.
- alu_result  in  32  combinational ALU output.
- br_taken  in  1  branch comparator result for decoder bop.
- rf_we  out  1  register-file write strobe.
- rf_wdata  out  32  register-file write data.
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  32  retired-instruction count.
- busy  out  1  high in any state but IDLE/FAULT.
- fault  out  1  sticky fault flag.
- fault_cause  out  2  00 none, 01 misaligned fetch, 10 fetch timeout.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, FAULT. Reset state IDLE.
- IDLE: no request. run=1 -> FETCH, else stay.
- FETCH, entry: clear timeout counter.
- FETCH, misaligned: if pc[1:0]!=0 -> FAULT, cause 01. imem_req is never asserted for a misaligned pc.
- FETCH, aligned: imem_req=1 and imem_addr=pc, both held stable until ack.
- FETCH, ack: ir<=imem_rdata -> DECODE.
- FETCH, timeout: with no ack and counter==FETCH_TIMEOUT-1 -> FAULT, cause 10. Otherwise counter++.
- DECODE: one cycle for decoder/regfile settle -> EXEC.
- EXEC: alu_q<=alu_result, br_q<=br_taken -> WB.
- WB, write: rf_we=dec_we. rf_wdata = dec_jmpe ? pc+4 : alu_q.
- WB, next PC: dec_jmpe -> alu_q & ~32'h1. Else dec_be & br_q -> alu_q. Else pc+4, all 32-bit wrap.
- WB, retire: retire=1, instret++ (wraps at 2^32). Then run=1 -> FETCH, else IDLE.
- Unknown opcode (decoder outputs all disabled): no write, pc+4, retires as a nop.
- FAULT: absorbing until rst_n. busy=0, imem_req=0, pc holds the faulting address.
- run changes only take effect in WB and IDLE; an instruction in flight always completes.
- imem_ack outside FETCH, or while pc is misaligned, is ignored.

## Timing
- Reset values: pc=RESET_PC, ir=0, imem_req=0, imem_addr=RESET_PC, rf_we=0, rf_wdata=0, retire=0, instret=0, busy=0, fault=0, fault_cause=00. alu_q, br_q and the timeout counter reset to 0.
- rst_n low at any state returns to IDLE asynchronously; any in-flight write is dropped.
- Minimum 4 cycles per instruction: FETCH with same-cycle ack, DECODE, EXEC, WB. Each extra wait cycle adds 1.
- rf_we, rf_wdata and retire are combinational from WB state. pc updates on the clock edge leaving WB.
- Ack arriving in the same cycle the counter reaches its limit: ack wins, no fault.
- With FETCH_TIMEOUT=N, the fault is entered after exactly N cycles of imem_req high.

## Test plan
- Reset, run=1, ack same cycle, imem_rdata=0x00500093 (addi x1,x0,5), alu_result=5 -> rf_we pulse in 4th cycle with rf_wdata=5; pc 0->4; instret=1.
- JAL at pc=0x10, dec_jmpe=1, dec_we=1, alu_result=0x18 -> rf_wdata=0x14, next pc=0x18.
- Branch at pc=0x20, dec_be=1, alu_result=0x40: br_taken=1 -> pc=0x40, rf_we=0; br_taken=0 -> pc=0x24.
- JALR with alu_result=0x103 -> pc=0x102; next FETCH -> fault=1, cause 01, imem_req never high; stays in FAULT until rst_n.
- FETCH_TIMEOUT=4, ack withheld -> fault cause 10 after 4 req cycles; repeat with ack in the 4th cycle -> no fault, DECODE follows.
- Drop run during EXEC -> WB still writes and retires, then IDLE with imem_req=0. Separately, assert rst_n low during EXEC -> all outputs return to reset values immediately and instret=0.
